echo_processor_param: RTL
=========================

Name: echo_processor_param

Overview:
- Parametrised successor to the single-channel fixed echo processor.
- Takes offset-binary ADC samples at a sample strobe and delays them through an internal circular buffer of runtime-selectable length.
- Produces feedback echo (y = x − q>>>G) or feedforward echo (y = x + xd>>>G).
- Emits offset-binary DAC samples.
- Sits between the ADC interface and the DAC driver; all logic is on one clock.

Parameters:
- DW, 10, sample width in bits (signed internally).
- DEPTH, 4096, delay buffer depth in samples; must be a power of 2.
- AW, $clog2(DEPTH), width of the delay-length and pointer fields.
- GAIN_SHIFT, 1, echo attenuation as an arithmetic right shift of the delayed sample.
- ADC_OFFSET, 10'h181, subtracted from data_in to form signed x (DW bits).
- DAC_OFFSET, 10'h200, added to signed y to form data_out (DW bits).

Ports:
- sysclk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  high = process samples; low = IDLE.
- sample_en  in  1  one-cycle sample strobe (e.g. the 10 kHz tick).
- mode  in  1  0 = feedback echo, 1 = feedforward echo.
- delay_len  in  AW  echo delay in samples, range 1..DEPTH−1; a value of 0 is treated as 1.
- data_in  in  DW  offset-binary ADC sample; valid when sample_en is high.
- data_out  out  DW  offset-binary DAC sample; registered.
- out_valid  out  1  one-cycle pulse when data_out updates.
- primed  out  1  high while in RUN (delay line holds valid history).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, wptr=0, fill_cnt=0, data_out=DAC_OFFSET, out_valid=0, primed=0, len_q=0.
  - Buffer RAM is not cleared.
- Arithmetic:
  - x = data_in − ADC_OFFSET, computed mod 2^DW and interpreted as signed.
  - y is computed in DW+2 signed bits, then reduced to DW bits (see Optional Feature).
  - The shift is arithmetic (>>>), so it rounds toward −inf.
- Delay line:
  - Read address raddr = wptr − len_eff (mod DEPTH), where len_eff = max(delay_len, 1).
  - Read is combinational.
  - On each sample_en in FILL or RUN: write mem[wptr] ← (mode ? x : y), then wptr ← wptr+1.
  - A value written at sample n is read at sample n+len_eff.
- States:
  - IDLE: data_out held at DAC_OFFSET, no writes, no out_valid. When enable=1 → FILL next cycle, with fill_cnt=0 and len_q=len_eff.
  - FILL: delayed term q forced to 0. Each sample_en produces an output and increments fill_cnt. When fill_cnt reaches len_q−1 on a sample_en → RUN.
  - RUN: q = mem[raddr]; primed=1.
  - Any state with enable=0 → IDLE next cycle; wptr is retained.
  - FILL or RUN, sample_en with len_eff ≠ len_q: treat as a FILL sample (q=0), set fill_cnt=1, len_q=len_eff, and go to FILL. Handle the delay_len=1 case consistently.
- Latency:
  - data_out and out_valid appear on the edge after the sample_en cycle, i.e. one cycle of latency.
  - out_valid is high for exactly one cycle per accepted sample.
- sample_en on consecutive cycles is legal; each strobe is processed independently, with full throughput.
- Output register: data_out = y[DW−1:0] + DAC_OFFSET (mod 2^DW).
- Wrap-around: wptr wraps from DEPTH−1 to 0 without a gap.

Optional Feature:
- ECHO_SATURATE_EN defined: y clamps to [−2^(DW−1), 2^(DW−1)−1] before the DAC offset is applied.
- ECHO_SATURATE_EN undefined: y is truncated to DW bits (two's-complement wrap); no clamp logic is built.

Decomposition:
- Package echo_pkg holds:
  - state enum (IDLE, FILL, RUN);
  - default ADC_OFFSET and DAC_OFFSET constants;
  - the function sat_dw(signed DW+2 → DW).
- One sub-module: echo_delay_ram.
  - DEPTH×DW, single write port, asynchronous read port.
  - Ports: sysclk, we, waddr, wdata, raddr, rdata.

Test Plan (DW=10, DEPTH=16, GAIN_SHIFT=1, delay_len=4):
- Feedback impulse: mode=0, one sample of 0x1E5 (x=+100) then 0x181 → data_out 0x264 at sample 0, 0x1CE (−50) at sample 4, 0x219 (+25) at sample 8, 0x1F3 (−13) at sample 12; 0x200 at all other samples.
- Feedforward impulse: mode=1, same stimulus → 0x264 at sample 0, 0x232 at sample 4, 0x200 at all other samples including sample 8.
- Saturation: mode=1, x=+400 (0x311) at samples 0 and 4 → sample 4 gives 0x3FF with ECHO_SATURATE_EN defined, 0x058 without it.
- Delay change in RUN: switch delay_len 4→6 after 10 samples → primed drops on that sample, q=0 for 6 samples, then primed=1 and the echo appears 6 samples after its source.
- Async reset mid-RUN: assert rst_n=0 between edges → data_out=0x200, out_valid=0, primed=0 immediately. After release with enable=1, sample 0 of the impulse gives 0x264 with no stale echo during FILL.
- Enable low: drop enable for 3 sample_en strobes → no out_valid and data_out=0x200 throughout; on re-enable, state passes through FILL again.

Source files
------------

// File: rtl/echo_pkg.sv
// Shared types, default converter offsets and the output clamp for the echo processor.
// sat_dw is only called when ECHO_SATURATE_EN is defined.
package echo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [9:0] ECHO_ADC_OFFSET = 10'h181;
    localparam logic [9:0] ECHO_DAC_OFFSET = 10'h200;

    // Clamp a sign-extended value into the signed range of a dw-bit word.
    function automatic logic signed [31:0] sat_dw(input logic signed [31:0] v,
                                                  input int unsigned       dw);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (dw - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/echo_delay_ram.sv
// Delay-line storage: one synchronous write port, one asynchronous read port.
module echo_delay_ram #(
    parameter int DW    = 10,
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          sysclk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge sysclk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/echo_processor_param.sv
// Parametrised feedback/feedforward echo processor between ADC and DAC.
// Define ECHO_SATURATE_EN to clamp y to DW bits instead of wrapping it.
module echo_processor_param
    import echo_pkg::*;
#(
    parameter int            DW         = 10,
    parameter int            DEPTH      = 4096,
    parameter int            AW         = $clog2(DEPTH),
    parameter int            GAIN_SHIFT = 1,
    parameter logic [DW-1:0] ADC_OFFSET = DW'(ECHO_ADC_OFFSET),
    parameter logic [DW-1:0] DAC_OFFSET = DW'(ECHO_DAC_OFFSET)
) (
    input  logic          sysclk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          sample_en,
    input  logic          mode,
    input  logic [AW-1:0] delay_len,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    output logic          out_valid,
    output logic          primed
);

    state_t r_state;
    state_t w_state_nxt;

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_fill_cnt;
    logic [AW-1:0] w_fill_nxt;
    logic [AW-1:0] r_len_q;
    logic [AW-1:0] w_len_q_nxt;
    logic [AW-1:0] w_len_eff;
    logic [AW-1:0] w_raddr;
    logic          w_len_chg;
    logic          w_accept;

    logic [DW-1:0]        w_rdata;
    logic [DW-1:0]        w_wdata;
    logic [DW-1:0]        w_y_dw;
    logic signed [DW-1:0] w_x;
    logic signed [DW-1:0] w_q;
    logic signed [DW+1:0] w_x_ext;
    logic signed [DW+1:0] w_q_ext;
    logic signed [DW+1:0] w_echo;
    logic signed [DW+1:0] w_y;

    logic [DW-1:0] r_dout_p1;
    logic          r_vld_p1;

    assign w_len_eff = (delay_len == '0) ? AW'(1) : delay_len;
    assign w_raddr   = r_wptr - w_len_eff;
    assign w_len_chg = (w_len_eff != r_len_q);
    assign w_accept  = enable && sample_en && (r_state != IDLE);

    echo_delay_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .sysclk (sysclk),
        .we     (w_accept),
        .waddr  (r_wptr),
        .wdata  (w_wdata),
        .raddr  (w_raddr),
        .rdata  (w_rdata)
    );

    // A changed delay length invalidates the history, so that sample behaves as a FILL sample.
    assign w_x     = signed'(data_in - ADC_OFFSET);
    assign w_q     = ((r_state == RUN) && !w_len_chg) ? signed'(w_rdata) : '0;
    assign w_x_ext = (DW+2)'(w_x);
    assign w_q_ext = (DW+2)'(w_q);

    // Feedback negates before shifting so the echo term itself rounds toward -inf.
    assign w_echo = mode ? (w_q_ext >>> GAIN_SHIFT) : ((-w_q_ext) >>> GAIN_SHIFT);
    assign w_y    = w_x_ext + w_echo;

`ifdef ECHO_SATURATE_EN
    assign w_y_dw = DW'(sat_dw(32'(w_y), DW));
`else
    assign w_y_dw = w_y[DW-1:0];
`endif

    assign w_wdata = mode ? $unsigned(w_x) : w_y_dw;

    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill_cnt;
        w_len_q_nxt = r_len_q;
        if (!enable) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = FILL;
                    w_fill_nxt  = '0;
                    w_len_q_nxt = w_len_eff;
                end
                FILL, RUN: begin
                    if (sample_en) begin
                        if (w_len_chg) begin
                            // The change sample is fill sample 0; a length of 1 is already full.
                            w_len_q_nxt = w_len_eff;
                            w_fill_nxt  = AW'(1);
                            w_state_nxt = (w_len_eff == AW'(1)) ? RUN : FILL;
                        end else if (r_state == FILL) begin
                            w_fill_nxt = r_fill_cnt + AW'(1);
                            if (r_fill_cnt == r_len_q - AW'(1)) begin
                                w_state_nxt = RUN;
                            end
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_wptr     <= '0;
            r_fill_cnt <= '0;
            r_len_q    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fill_cnt <= w_fill_nxt;
            r_len_q    <= w_len_q_nxt;
            if (w_accept) begin
                r_wptr <= r_wptr + AW'(1);
            end
        end
    end

    // Output stage: one register after the strobe cycle.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout_p1 <= DAC_OFFSET;
            r_vld_p1  <= 1'b0;
        end else begin
            r_vld_p1 <= w_accept;
            if (w_accept) begin
                r_dout_p1 <= w_y_dw + DAC_OFFSET;
            end else if (!enable || (r_state == IDLE)) begin
                r_dout_p1 <= DAC_OFFSET;
            end
        end
    end

    assign data_out  = r_dout_p1;
    assign out_valid = r_vld_p1;
    assign primed    = (r_state == RUN);

endmodule
